// File: rtl/codec_cfg_sequencer.sv
// Walks the ADAU1761 register table after reset and issues each entry as one I2C write,
// with power-up wait, per-entry settling delay and bounded NACK retries.
//
// state  | meaning
// IDLE   | waiting for auto-start after reset or a start pulse
// PWRUP  | codec power-up wait
// FETCH  | table address presented to ROM
// LATCH  | ROM word captured, terminator check
// ISSUE  | write request held until accepted
// RESP   | waiting for transaction completion
// DELAY  | settling wait after a flagged entry
// DONE   | all entries written
// ERROR  | retries exhausted on err_idx_o
module codec_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h3B,
    parameter int         ADDR_W         = 6,
    parameter int         POWERUP_CYCLES = 5_000_000,
    parameter int         DELAY_CYCLES   = 200_000,
    parameter int         MAX_RETRY      = 3,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [6:0]        req_dev_o,
    output logic [15:0]       req_reg_o,
    output logic [7:0]        req_data_o,
    input  logic              rsp_valid_i,
    input  logic              rsp_nack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] err_idx_o
);

    localparam int CNT_MAX = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Timers load N-1 and expire at zero, so a phase lasts exactly N cycles (0 behaves as 1).
    localparam logic [CNT_W-1:0]  PWR_LOAD = CNT_W'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  DLY_LOAD = CNT_W'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
    localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_LATCH, S_ISSUE, S_RESP, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              first_q, first_d;
    logic              req_valid_q, req_valid_d;
    logic [15:0]       req_reg_q, req_reg_d;
    logic [7:0]        req_data_q, req_data_d;
    logic              dly_q, dly_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_idx_q, err_idx_d;
    logic              advance;
    logic              unused_rsvd;

    assign unused_rsvd = ^rom_data_i[30:24];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        first_d     = 1'b0;
        req_valid_d = req_valid_q;
        req_reg_d   = req_reg_q;
        req_data_d  = req_data_q;
        dly_d       = dly_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_idx_d   = err_idx_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i || (state_q == S_IDLE && AUTO_START && first_q)) begin
                    state_d = S_PWRUP;
                    cnt_d   = PWR_LOAD;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_PWRUP: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (rom_data_i[23:8] == 16'hFFFF) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d     = S_ISSUE;
                    req_reg_d   = rom_data_i[23:8];
                    req_data_d  = rom_data_i[7:0];
                    dly_d       = rom_data_i[31];
                    retry_d     = '0;
                    req_valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (req_ready_i) begin
                    req_valid_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid_i) begin
                    if (!rsp_nack_i) begin
                        if (dly_q) begin
                            state_d = S_DELAY;
                            cnt_d   = DLY_LOAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end else if (retry_q < RTY_MAX) begin
                        retry_d     = retry_q + RTY_W'(1);
                        req_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        err_idx_d = idx_q;
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // The last table slot finishes the sequence instead of wrapping back to entry 0.
        if (advance) begin
            if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            first_q     <= 1'b1;
            req_valid_q <= 1'b0;
            req_reg_q   <= '0;
            req_data_q  <= '0;
            dly_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            first_q     <= first_d;
            req_valid_q <= req_valid_d;
            req_reg_q   <= req_reg_d;
            req_data_q  <= req_data_d;
            dly_q       <= dly_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign rom_addr_o  = idx_q;
    assign req_valid_o = req_valid_q;
    assign req_dev_o   = DEV_ADDR;
    assign req_reg_o   = req_reg_q;
    assign req_data_o  = req_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: ROM and I2C master models plus a table-walking reference
// that predicts every request, its start cycle and the final done/error outcome.
module tb_codec_cfg_sequencer;

    localparam int         ADDR_W = 2;
    localparam int         PWR    = 10;
    localparam int         DLY    = 30;
    localparam int         MAXR   = 3;
    localparam logic [6:0] DEV    = 7'h3B;
    localparam int         TMO    = 200;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              start_i;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [31:0]       rom_data_i;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [6:0]        req_dev_o;
    logic [15:0]       req_reg_o;
    logic [7:0]        req_data_o;
    logic              rsp_valid_i;
    logic              rsp_nack_i;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [ADDR_W-1:0] err_idx_o;

    int          nvec = 0;
    int          nmis = 0;
    logic [31:0] tbl [4];
    int          nacks [4];

    codec_cfg_sequencer #(
        .DEV_ADDR(DEV), .ADDR_W(ADDR_W), .POWERUP_CYCLES(PWR),
        .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR), .AUTO_START(1'b1)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_dev_o(req_dev_o),
        .req_reg_o(req_reg_o), .req_data_o(req_data_o),
        .rsp_valid_i(rsp_valid_i), .rsp_nack_i(rsp_nack_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) rom_data_i <= tbl[rom_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_entry(input bit term);
        logic [31:0] e;
        e = $urandom;
        if (term) e[23:8] = 16'hFFFF;
        else      e[23:8] = 16'($urandom_range(1, 65534));
        return e;
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Acts as the I2C master for one write; w counts negedges waited for req_valid_o.
    task automatic serve(input int rdy_wait, input int rsp_wait, input bit nack,
                         output int w, output logic [15:0] r, output logic [7:0] d, output bit ok);
        ok = 1'b1;
        w  = 0;
        r  = '0;
        d  = '0;
        while (req_valid_o !== 1'b1 && w < TMO) begin
            @(negedge clk_i);
            w++;
        end
        if (req_valid_o !== 1'b1) begin
            chk("req_timeout", 32'(req_valid_o), 32'd1);
            ok = 1'b0;
            return;
        end
        r = req_reg_o;
        d = req_data_o;
        chk("req_dev", 32'(req_dev_o), 32'(DEV));
        for (int i = 0; i < rdy_wait; i++) begin
            rsp_valid_i = (i == 0 && rdy_wait > 5);
            @(negedge clk_i);
            rsp_valid_i = 1'b0;
            chk("bp_valid", 32'(req_valid_o), 32'd1);
            chk("bp_reg", 32'(req_reg_o), 32'(r));
            chk("bp_data", 32'(req_data_o), 32'(d));
        end
        req_ready_i = 1'b1;
        @(negedge clk_i);
        req_ready_i = 1'b0;
        chk("valid_drop", 32'(req_valid_o), 32'd0);
        repeat (rsp_wait) @(negedge clk_i);
        rsp_valid_i = 1'b1;
        rsp_nack_i  = nack;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        rsp_nack_i  = 1'b0;
    endtask

    // Reference: walk the table entry by entry, nacks[i] NACKs before the ACK, at most
    // MAXR+1 attempts; predict each request, when it appears, and how the run ends.
    task automatic run_seq(input int first_wait, input int bp_first, input int rsp_fixed);
        int idx, att, w, nxt, end_k, eidx, rdy, rsp;
        bit fin, acked, nack, ok, e_done, e_err, first, saw;
        logic [15:0] r;
        logic [7:0]  d;
        idx = 0; nxt = first_wait; fin = 0; e_done = 0; e_err = 0; eidx = 0; end_k = 0; first = 1;
        while (!fin) begin
            if (tbl[idx][23:8] == 16'hFFFF) begin
                e_done = 1; end_k = nxt + 1; fin = 1;
            end else begin
                att = 0; acked = 0;
                while (!acked && !fin) begin
                    nack = (att < nacks[idx]);
                    rdy  = (first && bp_first >= 0) ? bp_first : int'($urandom_range(0, 3));
                    rsp  = (rsp_fixed >= 0) ? rsp_fixed : int'($urandom_range(0, 6));
                    serve(rdy, rsp, nack, w, r, d, ok);
                    first = 0;
                    if (!ok) return;
                    chk("req_wait", 32'(w), 32'(nxt));
                    chk("req_reg", 32'(r), 32'(tbl[idx][23:8]));
                    chk("req_data", 32'(d), 32'(tbl[idx][7:0]));
                    if (nack) begin
                        if (att == MAXR) begin
                            e_err = 1; eidx = idx; end_k = 1; fin = 1;
                        end else begin
                            att++; nxt = 0;
                        end
                    end else begin
                        acked = 1;
                        if (idx == 3) begin
                            e_done = 1; end_k = tbl[idx][31] ? DLY + 1 : 1; fin = 1;
                        end else begin
                            nxt = tbl[idx][31] ? DLY + 2 : 2;
                            idx++;
                        end
                    end
                end
            end
        end
        if (end_k > 1) begin
            repeat (end_k - 2) @(negedge clk_i);
            chk("pre_busy", 32'(busy_o), 32'd1);
            chk("pre_done", 32'(done_o), 32'd0);
            chk("pre_err", 32'(error_o), 32'd0);
            @(negedge clk_i);
        end
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("end_done", 32'(done_o), 32'(e_done));
        chk("end_err", 32'(error_o), 32'(e_err));
        if (e_err) chk("err_idx", 32'(err_idx_o), 32'(eidx));
        saw = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (req_valid_o !== 1'b0) saw = 1;
        end
        chk("no_extra_req", 32'(saw), 32'd0);
        chk("sticky_done", 32'(done_o), 32'(e_done));
        chk("sticky_err", 32'(error_o), 32'(e_err));
        if (e_done && idx == 3) chk("no_wrap", 32'(rom_addr_o), 32'd3);
    endtask

    task automatic load_table(input int term_pos, input int max_nack);
        for (int i = 0; i < 4; i++) begin
            tbl[i]   = rand_entry(i == term_pos);
            nacks[i] = int'($urandom_range(0, max_nack));
        end
    endtask

    initial begin
        int w0;
        int p;
        reset_ni = 1'b0; start_i = 1'b0; req_ready_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_nack_i = 1'b0;
        tbl[0] = {1'b0, 7'h00, 16'h4000, 8'h01};
        tbl[1] = {1'b1, 7'h00, 16'h4002, 8'h7F};
        tbl[2] = 32'h00FF_FF00;
        tbl[3] = rand_entry(1'b0);
        for (int i = 0; i < 4; i++) nacks[i] = 0;

        repeat (3) @(negedge clk_i);
        chk("rst_addr", 32'(rom_addr_o), 32'd0);
        chk("rst_valid", 32'(req_valid_o), 32'd0);
        chk("rst_reg", 32'(req_reg_o), 32'd0);
        chk("rst_data", 32'(req_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(error_o), 32'd0);
        chk("rst_eidx", 32'(err_idx_o), 32'd0);
        chk("rst_dev", 32'(req_dev_o), 32'(DEV));

        // nominal: auto-start, first request 12 clocks after the start edge, I2C ACK after 5
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("auto_busy", 32'(busy_o), 32'd1);
        run_seq(PWR + 2, -1, 5);

        // backpressure on the first request
        load_table(3, 0);
        pulse_start();
        chk("restart_done_clr", 32'(done_o), 32'd0);
        chk("restart_busy", 32'(busy_o), 32'd1);
        run_seq(PWR + 2, 20, -1);

        // entry 1 NACKed twice; a second start during power-up is ignored
        load_table(3, 0);
        nacks[1] = 2;
        pulse_start();
        repeat (3) @(negedge clk_i);
        pulse_start();
        run_seq(PWR - 2, -1, -1);

        // entry 2 always NACKed
        load_table(3, 0);
        nacks[2] = 99;
        pulse_start();
        run_seq(PWR + 2, -1, -1);

        // restart from ERROR, then reset while a request is pending
        load_table(3, 2);
        pulse_start();
        chk("err_clr", 32'(error_o), 32'd0);
        chk("err_clr_done", 32'(done_o), 32'd0);
        chk("err_rerun_busy", 32'(busy_o), 32'd1);
        w0 = 0;
        while (req_valid_o !== 1'b1 && w0 < TMO) begin
            @(negedge clk_i);
            w0++;
        end
        chk("rerun_reg", 32'(req_reg_o), 32'(tbl[0][23:8]));
        repeat (2) @(negedge clk_i);
        #1 reset_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(req_valid_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_addr", 32'(rom_addr_o), 32'd0);
        chk("arst_reg", 32'(req_reg_o), 32'd0);
        chk("arst_data", 32'(req_data_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("rerst_busy", 32'(busy_o), 32'd1);
        run_seq(PWR + 2, -1, -1);

        // random tables; the first pass fills all four slots with no terminator
        for (int it = 0; it < 4; it++) begin
            p = (it == 0) ? 4 : int'($urandom_range(1, 4));
            load_table(p, (it == 0) ? MAXR : MAXR + 1);
            pulse_start();
            run_seq(PWR + 2, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
